// File: rtl/sub_3p_if.sv
// Handshake and data bundle for the three-segment pipelined subtractor.
interface sub_3p_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] diff;
  logic             out_valid;
  logic             out_ready;
  logic             borrow;
  logic             ovf;
  logic             LSBs_Borrow;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output x, y, in_valid, out_ready,
    input  in_ready, diff, out_valid, borrow, ovf, LSBs_Borrow
  );

  // Subtractor side.
  modport slave (
    input  x, y, in_valid, out_ready,
    output in_ready, diff, out_valid, borrow, ovf, LSBs_Borrow
  );
endinterface

// File: rtl/sub_3p.sv
// Three-segment pipelined subtractor: diff = x - y mod 2^WIDTH.
// Segments are subtracted independently, then the borrows ripple one
// segment per stage so no borrow chain exceeds one segment plus one bit.
// A single global enable stalls every stage when the output is blocked.
module sub_3p #(
  parameter int WIDTH  = 24,
  parameter int WIDTH1 = 8,
  parameter int WIDTH2 = 8,
  parameter int WIDTH3 = 8
) (
  input logic    clk,
  input logic    reset,
  sub_3p_if.slave bus
);
  localparam int LO2 = WIDTH1;           // first bit of middle segment
  localparam int LO3 = WIDTH1 + WIDTH2;  // first bit of MSB segment

  logic en;

  // Stage A: registered operand segments and sign bits
  logic              a_valid;
  logic [WIDTH1-1:0] a_x1, a_y1;
  logic [WIDTH2-1:0] a_x2, a_y2;
  logic [WIDTH3-1:0] a_x3, a_y3;
  logic              a_xs, a_ys;

  // Stage B: independent per-segment differences and borrows
  logic              b_valid;
  logic [WIDTH1-1:0] b_d1;
  logic [WIDTH2-1:0] b_d2;
  logic [WIDTH3-1:0] b_d3;
  logic              b_b1, b_b2, b_b3;
  logic              b_xs, b_ys;

  // Stage C: LSB borrow folded into the middle segment
  logic              c_valid;
  logic [WIDTH1-1:0] c_d1;
  logic [WIDTH2-1:0] c_m;
  logic [WIDTH3-1:0] c_d3;
  logic              c_p2, c_b3;
  logic              c_xs, c_ys;

  // Stage D: output register
  logic              out_valid_reg;
  logic [WIDTH-1:0]  diff_reg;
  logic              borrow_reg;
  logic              ovf_reg;

  // Combinational segment arithmetic feeding each stage
  logic [WIDTH1:0]   sub1_next;
  logic [WIDTH2:0]   sub2_next;
  logic [WIDTH3:0]   sub3_next;
  logic [WIDTH2:0]   m_next;
  logic [WIDTH3:0]   h_next;
  logic [WIDTH-1:0]  diff_next;
  logic              ovf_next;

  assign en           = ~out_valid_reg | bus.out_ready;
  assign bus.in_ready = en;

  assign sub1_next = {1'b0, a_x1} - {1'b0, a_y1};
  assign sub2_next = {1'b0, a_x2} - {1'b0, a_y2};
  assign sub3_next = {1'b0, a_x3} - {1'b0, a_y3};
  assign m_next    = {1'b0, b_d2} - {{WIDTH2{1'b0}}, b_b1};
  assign h_next    = {1'b0, c_d3} - {{WIDTH3{1'b0}}, c_p2};
  assign diff_next = {h_next[WIDTH3-1:0], c_m, c_d1};
  assign ovf_next  = (c_xs != c_ys) & (diff_next[WIDTH-1] != c_xs);

  // Stage A: capture operands split into segments
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_x1 <= '0; a_y1 <= '0;
      a_x2 <= '0; a_y2 <= '0;
      a_x3 <= '0; a_y3 <= '0;
      a_xs <= 1'b0; a_ys <= 1'b0;
    end else if (en) begin
      a_valid <= bus.in_valid;
      a_x1 <= bus.x[WIDTH1-1:0];  a_y1 <= bus.y[WIDTH1-1:0];
      a_x2 <= bus.x[LO3-1:LO2];   a_y2 <= bus.y[LO3-1:LO2];
      a_x3 <= bus.x[WIDTH-1:LO3]; a_y3 <= bus.y[WIDTH-1:LO3];
      a_xs <= bus.x[WIDTH-1];     a_ys <= bus.y[WIDTH-1];
    end
  end

  // Stage B: subtract each segment on its own, keeping the raw borrows
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_valid <= 1'b0;
      b_d1 <= '0; b_d2 <= '0; b_d3 <= '0;
      b_b1 <= 1'b0; b_b2 <= 1'b0; b_b3 <= 1'b0;
      b_xs <= 1'b0; b_ys <= 1'b0;
    end else if (en) begin
      b_valid <= a_valid;
      b_d1 <= sub1_next[WIDTH1-1:0]; b_b1 <= sub1_next[WIDTH1];
      b_d2 <= sub2_next[WIDTH2-1:0]; b_b2 <= sub2_next[WIDTH2];
      b_d3 <= sub3_next[WIDTH3-1:0]; b_b3 <= sub3_next[WIDTH3];
      b_xs <= a_xs; b_ys <= a_ys;
    end
  end

  // Stage C: apply the LSB borrow to the middle segment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_d1 <= '0; c_m <= '0; c_d3 <= '0;
      c_p2 <= 1'b0; c_b3 <= 1'b0;
      c_xs <= 1'b0; c_ys <= 1'b0;
    end else if (en) begin
      c_valid <= b_valid;
      c_d1 <= b_d1;
      c_m  <= m_next[WIDTH2-1:0];
      c_p2 <= b_b2 | m_next[WIDTH2];
      c_d3 <= b_d3;
      c_b3 <= b_b3;
      c_xs <= b_xs; c_ys <= b_ys;
    end
  end

  // Stage D: apply the propagated borrow to the MSB segment and flag results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      diff_reg      <= '0;
      borrow_reg    <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (en) begin
      out_valid_reg <= c_valid;
      diff_reg      <= diff_next;
      borrow_reg    <= c_b3 | h_next[WIDTH3];
      ovf_reg       <= ovf_next;
    end
  end

  assign bus.out_valid   = out_valid_reg;
  assign bus.diff        = diff_reg;
  assign bus.borrow      = borrow_reg;
  assign bus.ovf         = ovf_reg;
  assign bus.LSBs_Borrow = b_b1;
endmodule

// File: tb/tb_sub_3p.sv
// Directed and randomised checks for the three-segment pipelined subtractor.
module tb_sub_3p;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sub_3p_if #(.WIDTH(24)) bus ();

  sub_3p #(.WIDTH(24), .WIDTH1(8), .WIDTH2(8), .WIDTH3(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [23:0] xv, input logic [23:0] yv, input logic v);
    bus.x        = xv;
    bus.y        = yv;
    bus.in_valid = v;
  endtask

  // One isolated operation through an empty pipeline with out_ready=1.
  task automatic run_one(input string tag, input logic [23:0] xv, input logic [23:0] yv,
                         input logic [23:0] ed, input logic eb, input logic eo,
                         input logic elsb);
    @(negedge clk); drive(xv, yv, 1'b1);
    @(negedge clk); bus.in_valid = 1'b0;            // accepted at edge k
    @(negedge clk); check({tag, "_lsb"}, 32'(bus.LSBs_Borrow), 32'(elsb));
    @(negedge clk); check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_diff"}, 32'(bus.diff), 32'(ed));
    check({tag, "_borrow"}, 32'(bus.borrow), 32'(eb));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    $display("txn %s: x=%06h y=%06h diff=%06h borrow=%0d ovf=%0d",
             tag, xv, yv, bus.diff, bus.borrow, bus.ovf);
  endtask

  // Reference result packed as {ovf, borrow, diff}.
  function automatic logic [25:0] model(input logic [23:0] xv, input logic [23:0] yv);
    logic [24:0] ud;
    int          sd;
    logic        o;
    ud = {1'b0, xv} - {1'b0, yv};
    sd = $signed({{8{xv[23]}}, xv}) - $signed({{8{yv[23]}}, yv});
    o  = (sd > 8388607) || (sd < -8388608);
    return {o, ud[24], ud[23:0]};
  endfunction

  logic [25:0] q[$];
  logic [25:0] e;
  int accepts = 0;
  int outs    = 0;

  initial begin
    reset         = 1'b1;
    bus.x         = '0;
    bus.y         = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_lsb", 32'(bus.LSBs_Borrow), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Directed vectors
    run_one("lsb_ripple",  24'h000100, 24'h000001, 24'h0000FF, 1'b0, 1'b0, 1'b1);
    run_one("dbl_ripple",  24'h010000, 24'h000001, 24'h00FFFF, 1'b0, 1'b0, 1'b1);
    run_one("wrap_under",  24'h000000, 24'h000001, 24'hFFFFFF, 1'b1, 1'b0, 1'b1);
    run_one("neg_ovf",     24'h800000, 24'h000001, 24'h7FFFFF, 1'b0, 1'b1, 1'b1);
    run_one("pos_ovf",     24'h7FFFFF, 24'hFFFFFF, 24'h800000, 1'b1, 1'b1, 1'b0);
    run_one("equal",       24'h123456, 24'h123456, 24'h000000, 1'b0, 1'b0, 1'b0);
    run_one("no_borrow",   24'h123456, 24'h012345, 24'h111111, 1'b0, 1'b0, 1'b0);

    // Stall and ordering: four back-to-back operands
    @(negedge clk); drive(24'd5, 24'd1, 1'b1);
    @(negedge clk); drive(24'd6, 24'd2, 1'b1);
    @(negedge clk); drive(24'd7, 24'd3, 1'b1);
    @(negedge clk); drive(24'd9, 24'd4, 1'b1);
    @(negedge clk);
    check("stall_first_valid", 32'(bus.out_valid), 32'd1);
    check("stall_first_diff", 32'(bus.diff), 32'd4);
    bus.out_ready = 1'b0;
    drive(24'd100, 24'd0, 1'b1);                   // must not be accepted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold_diff", 32'(bus.diff), 32'd4);
      check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk); check("order_1", 32'(bus.diff), 32'd4);
    check("order_1_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk); check("order_2", 32'(bus.diff), 32'd4);
    check("order_2_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk); check("order_3", 32'(bus.diff), 32'd5);
    check("order_3_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk); check("order_drained", 32'(bus.out_valid), 32'd0);
    $display("txn stall: results 4,4,4,5 sequence checked");

    // Reset mid-stream with a result on the output and three in flight
    @(negedge clk); drive(24'd0, 24'd1, 1'b1);
    @(negedge clk); drive(24'd3, 24'd1, 1'b1);
    @(negedge clk); drive(24'd4, 24'd1, 1'b1);
    @(negedge clk); drive(24'd8, 24'd1, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    check("pre_rst_diff", 32'(bus.diff), 32'hFFFFFF);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_diff", 32'(bus.diff), 32'd0);
    check("mid_rst_borrow", 32'(bus.borrow), 32'd0);
    check("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_stale", 32'(bus.out_valid), 32'd0);
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    end
    $display("txn reset: in-flight operands discarded");

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      bus.x         = 24'($urandom);
      bus.y         = 24'($urandom);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("rand_extra", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          check("rand_result", 32'({bus.ovf, bus.borrow, bus.diff}), 32'(e));
          outs++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.x, bus.y));
        accepts++;
      end
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("rand_extra", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          check("rand_result", 32'({bus.ovf, bus.borrow, bus.diff}), 32'(e));
          outs++;
        end
      end
    end
    check("rand_count", 32'(outs), 32'(accepts));
    $display("txn random: accepted=%0d delivered=%0d", accepts, outs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
